cmd_dispatch_fsm: RTL and testbench

CMD_DISPATCH_FSM -- requirements
Module: cmd_dispatch_fsm

---
 rtl/ctrl_types_pkg.sv | 42 ++++
 rtl/dispatch_timer.sv | 31 +++
 rtl/cmd_dispatch_fsm.sv | 150 +++++++++++++++
 tb/tb_cmd_dispatch_fsm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_types_pkg.sv
// Shared control types for the command dispatcher and its sub-FSMs.
//   op_e             : command opcode (NOP/GET/PUT/DEL)
//   dispatch_state_e : dispatcher FSM states
//   sub_cmd_t        : status reported by each sub-FSM
package ctrl_types_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned TIMER_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 2'd0,
        OP_GET = 2'd1,
        OP_PUT = 2'd2,
        OP_DEL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } dispatch_state_e;

    typedef struct packed {
        logic done;
    } sub_cmd_t;

    // Done flag of the sub-FSM selected by op; NOP has no sub-FSM.
    function automatic logic sel_done(input op_e op, input sub_cmd_t g,
                                      input sub_cmd_t p, input sub_cmd_t d);
        logic r;
        r = 1'b0;
        case (op)
            OP_GET:  r = g.done;
            OP_PUT:  r = p.done;
            OP_DEL:  r = d.done;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dispatch_timer.sv
// RUN-phase watchdog counter for cmd_dispatch_fsm.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart count from zero
//   inc      : count one RUN cycle without done
//   expired  : count has reached LIMIT-1
module dispatch_timer
    import ctrl_types_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TIMER_W-1:0] count_q;

    // Cycle counter; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + TIMER_W'(1);
        end
    end

    assign expired = (count_q == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/cmd_dispatch_fsm.sv
// Command dispatcher: accepts one command, restarts and drives the selected
// sub-FSM (GET/PUT/DEL) until it reports done, then holds a response until
// consumed. Optional RUN timeout under macro CMD_DISPATCH_TIMEOUT_EN.
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready/req_op     : command handshake
//   get/put/del_cmd                : sub-FSM status (.done)
//   get/put/del_enter              : one-cycle restart pulse
//   get/put/del_en                 : advance enable while running
//   resp_valid/resp_ready          : response handshake
//   resp_op, resp_err              : completed op, timeout abort flag
//   busy                           : not idle
module cmd_dispatch_fsm
    import ctrl_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     req_valid,
    output logic     req_ready,
    input  op_e      req_op,
    input  sub_cmd_t get_cmd,
    input  sub_cmd_t put_cmd,
    input  sub_cmd_t del_cmd,
    output logic     get_enter,
    output logic     put_enter,
    output logic     del_enter,
    output logic     get_en,
    output logic     put_en,
    output logic     del_en,
    output logic     resp_valid,
    input  logic     resp_ready,
    output op_e      resp_op,
    output logic     resp_err,
    output logic     busy
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cmd_dispatch_fsm: TIMEOUT_CYCLES out of range 2..65535");
    end

    dispatch_state_e state_q;
    op_e             op_q;
    logic            done_c;

    assign done_c  = sel_done(op_q, get_cmd, put_cmd, del_cmd);
    assign resp_op = op_q;

`ifdef CMD_DISPATCH_TIMEOUT_EN
    logic err_q;
    logic expired;

    dispatch_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == ST_ENTER),
        .inc     ((state_q == ST_RUN) && !done_c),
        .expired (expired)
    );

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Dispatcher FSM with registered outputs; enter/en default low so at
    // most one of them is ever set in a given cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            get_enter  <= 1'b0;
            put_enter  <= 1'b0;
            del_enter  <= 1'b0;
            get_en     <= 1'b0;
            put_en     <= 1'b0;
            del_en     <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            get_enter <= 1'b0;
            put_enter <= 1'b0;
            del_enter <= 1'b0;
            get_en    <= 1'b0;
            put_en    <= 1'b0;
            del_en    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef CMD_DISPATCH_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        if (req_op == OP_NOP) begin
                            state_q    <= ST_RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state_q   <= ST_ENTER;
                            get_enter <= (req_op == OP_GET);
                            put_enter <= (req_op == OP_PUT);
                            del_enter <= (req_op == OP_DEL);
                        end
                    end
                end
                ST_ENTER: begin
                    state_q <= ST_RUN;
                    get_en  <= (op_q == OP_GET);
                    put_en  <= (op_q == OP_PUT);
                    del_en  <= (op_q == OP_DEL);
                end
                ST_RUN: begin
                    // done beats a coinciding timeout
                    if (done_c) begin
                        state_q    <= ST_RESP;
                        resp_valid <= 1'b1;
`ifdef CMD_DISPATCH_TIMEOUT_EN
                        err_q      <= 1'b0;
                    end else if (expired) begin
                        state_q    <= ST_RESP;
                        resp_valid <= 1'b1;
                        err_q      <= 1'b1;
`endif
                    end else begin
                        get_en <= (op_q == OP_GET);
                        put_en <= (op_q == OP_PUT);
                        del_en <= (op_q == OP_DEL);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q    <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatch_fsm.sv
// Directed bench for cmd_dispatch_fsm. Inputs are driven and outputs sampled
// on the falling edge; the DUT updates on the rising edge.
module tb_cmd_dispatch_fsm;
    import ctrl_types_pkg::*;

`ifdef CMD_DISPATCH_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic     clk = 1'b0;
    logic     rst;
    logic     req_valid;
    logic     req_ready;
    op_e      req_op;
    sub_cmd_t get_cmd, put_cmd, del_cmd;
    logic     get_enter, put_enter, del_enter;
    logic     get_en, put_en, del_en;
    logic     resp_valid;
    logic     resp_ready;
    op_e      resp_op;
    logic     resp_err;
    logic     busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cmd_dispatch_fsm #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .get_cmd    (get_cmd),
        .put_cmd    (put_cmd),
        .del_cmd    (del_cmd),
        .get_enter  (get_enter),
        .put_enter  (put_enter),
        .del_enter  (del_enter),
        .get_en     (get_en),
        .put_en     (put_en),
        .del_en     (del_en),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_op    (resp_op),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    // {get_enter, put_enter, del_enter, get_en, put_en, del_en}
    logic [5:0] pulses;
    assign pulses = {get_enter, put_enter, del_enter, get_en, put_en, del_en};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks idle-state outputs.
    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 8'(req_ready), 8'd1);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
        chk({tag, "_rv"}, 8'(resp_valid), 8'd0);
        chk({tag, "_pulses"}, 8'(pulses), 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = OP_NOP; resp_ready = 1'b0;
        get_cmd = '0; put_cmd = '0; del_cmd = '0;
        @(negedge clk);
        tick();
        chk_idle("rst");
        chk("rst_err", 8'(resp_err), 8'd0);
        chk("rst_op", 8'(resp_op), 8'd0);
        // reset dominates a simultaneous request
        req_valid = 1'b1; req_op = OP_GET;
        tick();
        chk_idle("rst_prio");
        rst = 1'b0; req_valid = 1'b0;
        tick();

        // GET with done tied high: enter T+1, en T+2, resp T+3
        get_cmd.done = 1'b1;
        req_valid = 1'b1; req_op = OP_GET;
        tick();
        req_valid = 1'b0;
        chk("get_t1_pulses", 8'(pulses), 8'b100000);
        chk("get_t1_ready", 8'(req_ready), 8'd0);
        chk("get_t1_busy", 8'(busy), 8'd1);
        chk("get_t1_rv", 8'(resp_valid), 8'd0);
        tick();
        chk("get_t2_pulses", 8'(pulses), 8'b000100);
        tick();
        chk("get_t3_rv", 8'(resp_valid), 8'd1);
        chk("get_t3_op", 8'(resp_op), 8'd1);
        chk("get_t3_err", 8'(resp_err), 8'd0);
        chk("get_t3_pulses", 8'(pulses), 8'h00);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        get_cmd.done = 1'b0;
        chk_idle("get_done");

        // PUT: done in the 6th RUN cycle, response back-pressured 3 cycles
        req_valid = 1'b1; req_op = OP_PUT;
        tick();
        req_valid = 1'b0;
        chk("put_enter", 8'(pulses), 8'b010000);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("put_en_%0d", i), 8'(pulses), 8'b000010);
            chk($sformatf("put_rv_%0d", i), 8'(resp_valid), 8'd0);
            if (i == 5) put_cmd.done = 1'b1;
            tick();
        end
        put_cmd.done = 1'b0;
        // a new offer during RESP must not disturb the held response
        req_valid = 1'b1; req_op = OP_GET;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("put_hold_rv_%0d", i), 8'(resp_valid), 8'd1);
            chk($sformatf("put_hold_op_%0d", i), 8'(resp_op), 8'd2);
            chk($sformatf("put_hold_rdy_%0d", i), 8'(req_ready), 8'd0);
            chk($sformatf("put_hold_pl_%0d", i), 8'(pulses), 8'h00);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        // IDLE one cycle after resp_ready; the held offer was not taken early
        chk_idle("put_ret");
        tick();
        req_valid = 1'b0;
        chk("reaccept_enter", 8'(pulses), 8'b100000);
        tick();
        chk("reaccept_en", 8'(pulses), 8'b000100);
        // reset during RUN abandons the GET
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst_run");
        tick();
        chk_idle("rst_run2");

        // NOP: response at T+1, no pulses
        req_valid = 1'b1; req_op = OP_NOP;
        tick();
        req_valid = 1'b0;
        chk("nop_rv", 8'(resp_valid), 8'd1);
        chk("nop_op", 8'(resp_op), 8'd0);
        chk("nop_pulses", 8'(pulses), 8'h00);
        chk("nop_busy", 8'(busy), 8'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk_idle("nop_done");

        // PUT while GET reports done, then reset in RUN
        get_cmd.done = 1'b1;
        req_valid = 1'b1; req_op = OP_PUT;
        tick();
        req_valid = 1'b0;
        chk("x_enter", 8'(pulses), 8'b010000);
        tick();
        chk("x_en1", 8'(pulses), 8'b000010);
        tick();
        chk("x_en2", 8'(pulses), 8'b000010);
        chk("x_rv", 8'(resp_valid), 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        get_cmd.done = 1'b0;
        chk_idle("x_rst");

        // DEL with done in first RUN cycle
        del_cmd.done = 1'b1;
        req_valid = 1'b1; req_op = OP_DEL;
        tick();
        req_valid = 1'b0;
        chk("del_enter", 8'(pulses), 8'b001000);
        tick();
        chk("del_en", 8'(pulses), 8'b000001);
        tick();
        chk("del_rv", 8'(resp_valid), 8'd1);
        chk("del_op", 8'(resp_op), 8'd3);
        del_cmd.done = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk_idle("del_ret");

`ifdef CMD_DISPATCH_TIMEOUT_EN
        // DEL never done: abort after 4 RUN cycles
        req_valid = 1'b1; req_op = OP_DEL;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_en_%0d", i), 8'(pulses), 8'b000001);
            tick();
        end
        chk("to_rv", 8'(resp_valid), 8'd1);
        chk("to_err", 8'(resp_err), 8'd1);
        chk("to_pulses", 8'(pulses), 8'h00);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        // done coincides with the limit on the 4th RUN cycle
        req_valid = 1'b1; req_op = OP_DEL;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to2_en_%0d", i), 8'(pulses), 8'b000001);
            if (i == 3) del_cmd.done = 1'b1;
            tick();
        end
        del_cmd.done = 1'b0;
        chk("to2_rv", 8'(resp_valid), 8'd1);
        chk("to2_err", 8'(resp_err), 8'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk_idle("to2_ret");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
